controlador_voltas: RTL and testbench

Sequencing controller for the stopwatch datapath. It turns single-cycle button pulses into the run/pause/clear state of the BCD counter and manages the lap memory: write address, occupancy, and read-back cycling. It sits between the edge detectors and the counter/memory instances, replacing the free-running address registers in the top level. The 100 Hz counter and the memory stay unchanged; this block only drives their enable, clear, write-enable and address inputs.

---
 rtl/controlador_voltas_pkg.sv | 15 +
 rtl/controlador_voltas_ponteiro.sv | 90 +++++++++
 rtl/controlador_voltas.sv | 126 ++++++++++++
 tb/tb_controlador_voltas.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/controlador_voltas_pkg.sv
// Shared types and defaults for the stopwatch sequencing controller.
// State encoding, lap memory geometry and lap counter width.
package controlador_voltas_pkg;

    typedef enum logic [1:0] {
        PARADO   = 2'd0,
        CONTANDO = 2'd1,
        PAUSADO  = 2'd2
    } estado_t;

    localparam int DEPTH_DEF  = 4;
    localparam int ADDR_W_DEF = 2;
    localparam int CNT_W_DEF  = ADDR_W_DEF + 1;

endpackage

// File: rtl/controlador_voltas_ponteiro.sv
// ponteiro_voltas: lap log pointers (write slot, occupancy, read-back index)
// and the registered read address into the circular lap memory.
module ponteiro_voltas
    import controlador_voltas_pkg::*;
#(
    parameter int DEPTH  = DEPTH_DEF,
    parameter int ADDR_W = ADDR_W_DEF
) (
    input  logic              i_clock,
    input  logic              i_reset,
    input  logic              i_log_clear,
    input  logic              i_lap_write,
    input  logic              i_read_pulse,
    output logic [ADDR_W-1:0] o_wr_ptr,
    output logic [ADDR_W:0]   o_lap_count,
    output logic [ADDR_W-1:0] o_read_index,
    output logic [ADDR_W-1:0] o_mem_raddr,
    output logic              o_full,
    output logic              o_empty
);

    localparam logic [ADDR_W:0] L_DEPTH = (ADDR_W + 1)'(DEPTH);

    logic [ADDR_W-1:0] r_wr;
    logic [ADDR_W:0]   r_cnt;
    logic [ADDR_W-1:0] r_ri;
    logic [ADDR_W-1:0] r_raddr;
    logic              r_full;
    logic              r_empty;

    logic [ADDR_W-1:0] w_wr_nx;
    logic [ADDR_W:0]   w_cnt_nx;
    logic [ADDR_W-1:0] w_ri_nx;
    logic              w_full_nx;
    logic [ADDR_W-1:0] w_oldest_nx;
    logic [ADDR_W-1:0] w_raddr_nx;

    always_comb begin
        w_wr_nx  = r_wr;
        w_cnt_nx = r_cnt;
        w_ri_nx  = r_ri;
        if (i_log_clear) begin
            w_wr_nx  = '0;
            w_cnt_nx = '0;
            w_ri_nx  = '0;
        end else begin
            if (i_lap_write) begin
                w_wr_nx = r_wr + 1'b1;
                if (r_cnt != L_DEPTH)
                    w_cnt_nx = r_cnt + 1'b1;
            end
            // Wrap uses the occupancy before this cycle's lap.
            if (i_read_pulse && (r_cnt != '0)) begin
                if ({1'b0, r_ri} == (r_cnt - 1'b1))
                    w_ri_nx = '0;
                else
                    w_ri_nx = r_ri + 1'b1;
            end
        end
        w_full_nx   = (w_cnt_nx == L_DEPTH);
        w_oldest_nx = w_full_nx ? w_wr_nx : '0;
        w_raddr_nx  = w_oldest_nx + w_ri_nx;
    end

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_wr    <= '0;
            r_cnt   <= '0;
            r_ri    <= '0;
            r_raddr <= '0;
            r_full  <= 1'b0;
            r_empty <= 1'b1;
        end else begin
            r_wr    <= w_wr_nx;
            r_cnt   <= w_cnt_nx;
            r_ri    <= w_ri_nx;
            r_raddr <= w_raddr_nx;
            r_full  <= w_full_nx;
            r_empty <= (w_cnt_nx == '0);
        end
    end

    assign o_wr_ptr     = r_wr;
    assign o_lap_count  = r_cnt;
    assign o_read_index = r_ri;
    assign o_mem_raddr  = r_raddr;
    assign o_full       = r_full;
    assign o_empty      = r_empty;

endmodule

// File: rtl/controlador_voltas.sv
// Stopwatch run/pause/clear FSM and lap-capture control.
// CONTROLADOR_VOLTAS_OVERWRITE_EN: laps while full overwrite the oldest slot.
module controlador_voltas
    import controlador_voltas_pkg::*;
#(
    parameter int DEPTH  = DEPTH_DEF,
    parameter int ADDR_W = ADDR_W_DEF
) (
    input  logic              i_clock,
    input  logic              i_reset,
    input  logic              i_start_stop_pulse,
    input  logic              i_lap_pulse,
    input  logic              i_read_pulse,
    input  logic              i_clear_pulse,
    output logic              o_counter_enable,
    output logic              o_counter_clear,
    output logic              o_mem_we,
    output logic [ADDR_W-1:0] o_mem_waddr,
    output logic [ADDR_W-1:0] o_mem_raddr,
    output logic [ADDR_W:0]   o_lap_count,
    output logic [ADDR_W-1:0] o_read_index,
    output logic              o_full,
    output logic              o_empty,
    output logic              o_lap_rejected
);

    estado_t           r_st;
    logic              r_ce;
    logic              r_cc;
    logic              r_we;
    logic [ADDR_W-1:0] r_waddr;
    logic              r_rej;

    estado_t           w_st_nx;
    logic              w_clr_cnt;
    logic              w_log_clr;
    logic              w_lap_ok;
    logic              w_lap_wr;
    logic              w_rej;
    logic              w_full;
    logic [ADDR_W-1:0] w_wr_ptr;

    always_comb begin
        w_st_nx   = r_st;
        w_clr_cnt = 1'b0;
        w_log_clr = 1'b0;
        w_lap_ok  = 1'b0;
        unique case (r_st)
            PARADO: begin
                if (i_clear_pulse)
                    w_log_clr = 1'b1;
                else if (i_start_stop_pulse)
                    w_st_nx = CONTANDO;
            end
            CONTANDO: begin
                if (i_start_stop_pulse)
                    w_st_nx = PAUSADO;
                w_lap_ok = i_lap_pulse;
            end
            PAUSADO: begin
                // Clear outranks both start_stop and a same-cycle lap.
                if (i_clear_pulse) begin
                    w_st_nx   = PARADO;
                    w_clr_cnt = 1'b1;
                end else begin
                    if (i_start_stop_pulse)
                        w_st_nx = CONTANDO;
                    w_lap_ok = i_lap_pulse;
                end
            end
            default: w_st_nx = PARADO;
        endcase
    end

`ifdef CONTROLADOR_VOLTAS_OVERWRITE_EN
    assign w_lap_wr = w_lap_ok;
    assign w_rej    = 1'b0;
`else
    assign w_lap_wr = w_lap_ok && !w_full;
    assign w_rej    = w_lap_ok && w_full;
`endif

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_st    <= PARADO;
            r_ce    <= 1'b0;
            r_cc    <= 1'b0;
            r_we    <= 1'b0;
            r_waddr <= '0;
            r_rej   <= 1'b0;
        end else begin
            r_st  <= w_st_nx;
            r_ce  <= (w_st_nx == CONTANDO);
            r_cc  <= w_clr_cnt;
            r_we  <= w_lap_wr;
            r_rej <= w_rej;
            if (w_lap_wr)
                r_waddr <= w_wr_ptr;
        end
    end

    ponteiro_voltas #(
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) u_ponteiro (
        .i_clock      (i_clock),
        .i_reset      (i_reset),
        .i_log_clear  (w_log_clr),
        .i_lap_write  (w_lap_wr),
        .i_read_pulse (i_read_pulse),
        .o_wr_ptr     (w_wr_ptr),
        .o_lap_count  (o_lap_count),
        .o_read_index (o_read_index),
        .o_mem_raddr  (o_mem_raddr),
        .o_full       (w_full),
        .o_empty      (o_empty)
    );

    assign o_counter_enable = r_ce;
    assign o_counter_clear  = r_cc;
    assign o_mem_we         = r_we;
    assign o_mem_waddr      = r_waddr;
    assign o_full           = w_full;
    assign o_lap_rejected   = r_rej;

endmodule

// File: tb/tb_controlador_voltas.sv
// Directed bench for controlador_voltas: FSM, lap log, read-back, clears.
module tb_controlador_voltas;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       ss  = 1'b0;
    logic       lap = 1'b0;
    logic       rd  = 1'b0;
    logic       clr = 1'b0;
    logic       ce, cc, we, full, empty, rej;
    logic [1:0] waddr, raddr, ri;
    logic [2:0] cnt;

    int pass_cnt = 0;
    int total    = 0;

    always #5 clk = ~clk;

    controlador_voltas dut (
        .i_clock            (clk),
        .i_reset            (rst),
        .i_start_stop_pulse (ss),
        .i_lap_pulse        (lap),
        .i_read_pulse       (rd),
        .i_clear_pulse      (clr),
        .o_counter_enable   (ce),
        .o_counter_clear    (cc),
        .o_mem_we           (we),
        .o_mem_waddr        (waddr),
        .o_mem_raddr        (raddr),
        .o_lap_count        (cnt),
        .o_read_index       (ri),
        .o_full             (full),
        .o_empty            (empty),
        .o_lap_rejected     (rej)
    );

    // Drive at a falling edge, return at the next falling edge.
    task automatic step(input logic s, input logic l,
                        input logic r, input logic c);
        ss  = s;
        lap = l;
        rd  = r;
        clr = c;
        @(negedge clk);
        ss  = 1'b0;
        lap = 1'b0;
        rd  = 1'b0;
        clr = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step(0, 0, 0, 0);
        step(0, 0, 0, 0);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        total++;
        if ({ce, cc, we, rej, full, empty} !== 6'b000001)
            $display("FAIL reset_flags got %b want 000001",
                     {ce, cc, we, rej, full, empty});
        else pass_cnt++;
        total++;
        if ({waddr, raddr, ri, cnt} !== 9'd0)
            $display("FAIL reset_vals got %h want 0",
                     {waddr, raddr, ri, cnt});
        else pass_cnt++;
        step(0, 0, 1, 0);
        total++;
        if (ri !== 2'd0 || raddr !== 2'd0)
            $display("FAIL read_empty got ri=%0d ra=%0d want 0 0", ri, raddr);
        else pass_cnt++;
    endtask

    task automatic test_start_stop();
        do_reset();
        step(1, 0, 0, 0);
        total++;
        if (ce !== 1'b1) $display("FAIL ss_run got %b want 1", ce);
        else pass_cnt++;
        step(0, 0, 0, 0);
        total++;
        if (ce !== 1'b1) $display("FAIL ss_hold got %b want 1", ce);
        else pass_cnt++;
        step(1, 0, 0, 0);
        total++;
        if (ce !== 1'b0) $display("FAIL ss_pause got %b want 0", ce);
        else pass_cnt++;
    endtask

    task automatic test_laps();
        do_reset();
        step(1, 0, 0, 0);
        for (int i = 0; i < 3; i++) begin
            step(0, 1, 0, 0);
            total++;
            if (we !== 1'b1 || waddr !== 2'(i) || cnt !== 3'(i + 1))
                $display("FAIL lap%0d got we=%b wa=%0d n=%0d want 1 %0d %0d",
                         i, we, waddr, cnt, i, i + 1);
            else pass_cnt++;
            step(0, 0, 0, 0);
            total++;
            if (we !== 1'b0) $display("FAIL lap%0d_we_off got %b want 0", i, we);
            else pass_cnt++;
        end
        total++;
        if (cnt !== 3'd3 || empty !== 1'b0 || full !== 1'b0)
            $display("FAIL laps3 got n=%0d e=%b f=%b want 3 0 0",
                     cnt, empty, full);
        else pass_cnt++;
    endtask

    task automatic test_full();
        do_reset();
        step(1, 0, 0, 0);
        for (int i = 0; i < 4; i++) begin
            step(0, 1, 0, 0);
            total++;
            if (we !== 1'b1 || waddr !== 2'(i))
                $display("FAIL b2b%0d got we=%b wa=%0d want 1 %0d",
                         i, we, waddr, i);
            else pass_cnt++;
        end
        total++;
        if (full !== 1'b1 || cnt !== 3'd4 || raddr !== 2'd0)
            $display("FAIL full got f=%b n=%0d ra=%0d want 1 4 0",
                     full, cnt, raddr);
        else pass_cnt++;
        step(0, 1, 0, 0);
`ifdef CONTROLADOR_VOLTAS_OVERWRITE_EN
        total++;
        if (we !== 1'b1 || waddr !== 2'd0 || rej !== 1'b0 ||
            cnt !== 3'd4 || raddr !== 2'd1)
            $display("FAIL overwrite got we=%b wa=%0d rj=%b n=%0d ra=%0d want 1 0 0 4 1",
                     we, waddr, rej, cnt, raddr);
        else pass_cnt++;
`else
        total++;
        if (we !== 1'b0 || rej !== 1'b1 || cnt !== 3'd4 || raddr !== 2'd0)
            $display("FAIL reject got we=%b rj=%b n=%0d ra=%0d want 0 1 4 0",
                     we, rej, cnt, raddr);
        else pass_cnt++;
`endif
        step(0, 0, 0, 0);
        total++;
        if (rej !== 1'b0 || we !== 1'b0)
            $display("FAIL reject_off got rj=%b we=%b want 0 0", rej, we);
        else pass_cnt++;
    endtask

    task automatic test_read();
        logic [1:0] exp_ri [3];
        exp_ri[0] = 2'd1;
        exp_ri[1] = 2'd0;
        exp_ri[2] = 2'd1;
        do_reset();
        step(1, 0, 0, 0);
        step(0, 1, 0, 0);
        step(0, 1, 0, 0);
        for (int i = 0; i < 3; i++) begin
            step(0, 0, 1, 0);
            total++;
            if (ri !== exp_ri[i] || raddr !== exp_ri[i])
                $display("FAIL read%0d got ri=%0d ra=%0d want %0d",
                         i, ri, raddr, exp_ri[i]);
            else pass_cnt++;
        end
    endtask

    task automatic test_clear();
        // Continues from test_read: counting, two laps logged.
        step(0, 0, 0, 1);
        total++;
        if (cc !== 1'b0 || ce !== 1'b1 || cnt !== 3'd2)
            $display("FAIL clr_run got cc=%b ce=%b n=%0d want 0 1 2",
                     cc, ce, cnt);
        else pass_cnt++;
        step(1, 0, 0, 0);
        step(0, 0, 0, 1);
        total++;
        if (cc !== 1'b1 || ce !== 1'b0 || cnt !== 3'd2)
            $display("FAIL clr_pause got cc=%b ce=%b n=%0d want 1 0 2",
                     cc, ce, cnt);
        else pass_cnt++;
        step(0, 1, 0, 0);
        total++;
        if (cc !== 1'b0 || we !== 1'b0 || rej !== 1'b0 || cnt !== 3'd2)
            $display("FAIL idle_lap got cc=%b we=%b rj=%b n=%0d want 0 0 0 2",
                     cc, we, rej, cnt);
        else pass_cnt++;
        step(0, 0, 0, 1);
        total++;
        if (cnt !== 3'd0 || empty !== 1'b1 || ri !== 2'd0 || cc !== 1'b0)
            $display("FAIL erase got n=%0d e=%b ri=%0d cc=%b want 0 1 0 0",
                     cnt, empty, ri, cc);
        else pass_cnt++;
    endtask

    task automatic test_combined();
        do_reset();
        step(1, 0, 0, 0);
        step(1, 1, 0, 0);
        total++;
        if (we !== 1'b1 || waddr !== 2'd0 || ce !== 1'b0 || cnt !== 3'd1)
            $display("FAIL ss_lap got we=%b wa=%0d ce=%b n=%0d want 1 0 0 1",
                     we, waddr, ce, cnt);
        else pass_cnt++;
        step(0, 1, 0, 1);
        total++;
        if (we !== 1'b0 || cc !== 1'b1 || cnt !== 3'd1 || rej !== 1'b0)
            $display("FAIL clr_lap got we=%b cc=%b n=%0d rj=%b want 0 1 1 0",
                     we, cc, cnt, rej);
        else pass_cnt++;
    endtask

    task automatic test_reset_mid();
        do_reset();
        step(1, 0, 0, 0);
        step(0, 1, 0, 0);
        rst = 1'b1;
        step(0, 1, 0, 0);
        rst = 1'b0;
        total++;
        if ({ce, cc, we, rej, full, empty} !== 6'b000001 ||
            {waddr, raddr, ri, cnt} !== 9'd0)
            $display("FAIL reset_mid got %b/%h want 000001/0",
                     {ce, cc, we, rej, full, empty},
                     {waddr, raddr, ri, cnt});
        else pass_cnt++;
    endtask

    initial begin
        @(negedge clk);
        test_reset();
        test_start_stop();
        test_laps();
        test_full();
        test_read();
        test_clear();
        test_combined();
        test_reset_mid();
        $display("%0d/%0d checks passed", pass_cnt, total);
        $finish;
    end

endmodule
